// File: rtl/regbank16.sv
// regbank16 - sixteen-entry register bank with a per-register busy scoreboard.
//
// Feeds the 16-to-1 operand multiplexer: r0..r15 present every register in
// parallel and connect one-to-one to a0..a15 of mux16to1. Register 0 reads as
// zero and can never be written or reserved.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      asynchronous, active-high; clears data and busy bits at once
//   wr_en      write-back strobe
//   wr_addr    write-back destination index
//   wr_data    write-back value
//   rsv_en     reservation request (instruction issue)
//   rsv_addr   register to mark busy
//   r0..r15    registered register contents
//   busy       bit n set = register n has an outstanding reservation
//   rsv_stall  combinational; reservation refused this cycle (WAW hazard)
module regbank16 #(
  parameter int unsigned size = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [size-1:0] wr_data,
  input  logic            rsv_en,
  input  logic [3:0]      rsv_addr,
  output logic [size-1:0] r0,
  output logic [size-1:0] r1,
  output logic [size-1:0] r2,
  output logic [size-1:0] r3,
  output logic [size-1:0] r4,
  output logic [size-1:0] r5,
  output logic [size-1:0] r6,
  output logic [size-1:0] r7,
  output logic [size-1:0] r8,
  output logic [size-1:0] r9,
  output logic [size-1:0] r10,
  output logic [size-1:0] r11,
  output logic [size-1:0] r12,
  output logic [size-1:0] r13,
  output logic [size-1:0] r14,
  output logic [size-1:0] r15,
  output logic [15:0]     busy,
  output logic            rsv_stall
);

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } reg_state_t;

  logic [size-1:0] regs  [1:15];
  reg_state_t      state [1:15];

  logic addr_wr_nz;
  logic addr_rsv_nz;
  logic wr_same_rsv;

  assign addr_wr_nz  = (wr_addr != 4'd0);
  assign addr_rsv_nz = (rsv_addr != 4'd0);
  assign wr_same_rsv = wr_en && (wr_addr == rsv_addr);

  // A write-back to the reserved register in the same cycle retires the old
  // owner, so the new reservation is allowed through instead of stalling.
  always_comb begin
    rsv_stall = rsv_en && addr_rsv_nz && busy[rsv_addr] && !wr_same_rsv;
  end

  assign busy[0] = 1'b0;

  for (genvar g = 1; g < 16; g++) begin : g_reg
    localparam logic [3:0] IDX = 4'(g);

    logic wr_hit;
    logic rsv_take;

    assign wr_hit   = wr_en && addr_wr_nz && (wr_addr == IDX);
    assign rsv_take = rsv_en && addr_rsv_nz && (rsv_addr == IDX) && !rsv_stall;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        regs[g]  <= '0;
        state[g] <= FREE;
      end else begin
        if (wr_hit) begin
          regs[g] <= wr_data;
        end
        case (state[g])
          FREE: if (rsv_take) state[g] <= BUSY;
          BUSY: if (wr_hit && !rsv_take) state[g] <= FREE;
          default: state[g] <= FREE;
        endcase
      end
    end

    assign busy[g] = (state[g] == BUSY);
  end

  assign r0  = '0;
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule

// File: tb/tb_regbank16.sv
// tb_regbank16 - scoreboard bench for regbank16.
// The driver applies one operation per cycle, derives the expected stall and
// next register/busy contents from a plain array model, and queues them. The
// monitor pops each entry and checks rsv_stall within the cycle and the
// register outputs and busy after the capturing edge.
module tb_regbank16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [31:0] r8, r9, r10, r11, r12, r13, r14, r15;
  logic [15:0] busy;
  logic        rsv_stall;

  logic [31:0] rv [16];
  assign rv[0] = r0;   assign rv[1] = r1;   assign rv[2] = r2;   assign rv[3] = r3;
  assign rv[4] = r4;   assign rv[5] = r5;   assign rv[6] = r6;   assign rv[7] = r7;
  assign rv[8] = r8;   assign rv[9] = r9;   assign rv[10] = r10; assign rv[11] = r11;
  assign rv[12] = r12; assign rv[13] = r13; assign rv[14] = r14; assign rv[15] = r15;

  regbank16 #(.size(32)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .busy(busy), .rsv_stall(rsv_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_reset;
    logic         exp_stall;
    logic [15:0]  exp_busy;
    logic [511:0] exp_r;
  } item_t;

  item_t sb [$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: architectural register file and busy flags.
  logic [31:0] m_reg [16];
  logic [15:0] m_busy;

  function automatic item_t snapshot(input logic is_rst, input logic stall);
    item_t it;
    it.is_reset  = is_rst;
    it.exp_stall = stall;
    it.exp_busy  = m_busy;
    for (int k = 0; k < 16; k++) it.exp_r[k*32 +: 32] = m_reg[k];
    return it;
  endfunction

  task automatic step(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic re, input logic [3:0] ra);
    logic stall;
    @(negedge clk);
    reset    = 1'b0;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
    #1;
    stall = re && (ra != 4'd0) && m_busy[ra] && !(we && wa == ra);
    if (we && wa != 4'd0) begin
      m_reg[wa]  = wd;
      m_busy[wa] = 1'b0;
    end
    if (re && ra != 4'd0 && !stall) m_busy[ra] = 1'b1;
    sb.push_back(snapshot(1'b0, stall));
  endtask

  // Reset raised between edges with traffic pending; it must clear at once
  // and the pending operation must be lost.
  task automatic step_reset();
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 4'(1 + $urandom_range(0, 14));
    wr_data  = $urandom;
    rsv_en   = 1'b1;
    rsv_addr = 4'(1 + $urandom_range(0, 14));
    #1;
    reset = 1'b1;
    for (int k = 0; k < 16; k++) m_reg[k] = '0;
    m_busy = '0;
    sb.push_back(snapshot(1'b1, 1'b0));
  endtask

  task automatic check_state(input item_t it, input string tag);
    for (int k = 0; k < 16; k++) begin
      vectors++;
      if (rv[k] !== it.exp_r[k*32 +: 32]) begin
        miscompares++;
        $display("FAIL %s r%0d: got %h expected %h", tag, k, rv[k], it.exp_r[k*32 +: 32]);
      end
    end
    vectors++;
    if (busy !== it.exp_busy) begin
      miscompares++;
      $display("FAIL %s busy: got %h expected %h", tag, busy, it.exp_busy);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        it = sb.pop_front();
        if (it.is_reset) check_state(it, "reset_now");
        vectors++;
        if (rsv_stall !== it.exp_stall) begin
          miscompares++;
          $display("FAIL rsv_stall: got %b expected %b (rsv %b@%0d wr %b@%0d)",
                   rsv_stall, it.exp_stall, rsv_en, rsv_addr, wr_en, wr_addr);
        end
        @(posedge clk);
        #1;
        check_state(it, it.is_reset ? "reset_post" : "post");
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int unsigned drain;
    for (int k = 0; k < 16; k++) m_reg[k] = '0;
    m_busy = '0;

    step_reset();
    step(1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0);
    step(1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd7);
    step(1'b1, 4'd7, 32'hA5A5A5A5, 1'b0, 4'd0);
    step(1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    step(1'b1, 4'd9, 32'h00000001, 1'b1, 4'd9);
    step_reset();
    step(1'b1, 4'd2, 32'h00000055, 1'b1, 4'd14);
    step(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd5);
    step_reset();

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        step_reset();
      end else begin
        logic [3:0] wa, ra;
        if ($urandom_range(0, 3) == 0) begin
          wa = 4'($urandom_range(0, 15));
          ra = 4'($urandom_range(0, 15));
        end else begin
          wa = 4'($urandom_range(0, 4));
          ra = 4'($urandom_range(0, 4));
        end
        step(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra);
      end
    end

    @(negedge clk);
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    drain = 0;
    while (sb.size() != 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
